// File: rtl/branch_predictor.sv
// 2-bit saturating-counter branch history table: combinational lookup in ID,
// resolution and training in EX, plus branch / mispredict performance counters.
module branch_predictor #(
   parameter int IDX_W = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ID_Branch_i,
   input  logic [XLEN-1:0] ID_PC_i,
   input  logic [XLEN-1:0] ID_Target_i,
   output logic            ID_PredTaken_o,
   output logic [XLEN-1:0] ID_PredTarget_o,
   input  logic            WriteEX_i,
   input  logic            FlushEX_i,
   input  logic            WriteMEM_i,
   input  logic            EX_Taken_i,
   output logic            EX_WrongPredict_o,
   output logic [XLEN-1:0] EX_RecoverPC_o,
   output logic [31:0]     BrCnt_o,
   output logic [31:0]     MissCnt_o
);

   localparam int DEPTH = 1 << IDX_W;

   logic [1:0]       r_bht [DEPTH];

   logic             r_ex_valid;
   logic             r_ex_pred;
   logic [IDX_W-1:0] r_ex_idx;
   logic [XLEN-1:0]  r_ex_pcplus4;
   logic [XLEN-1:0]  r_ex_target;

   logic [31:0]      r_br_cnt;
   logic [31:0]      r_miss_cnt;

   logic [IDX_W-1:0] w_id_idx;
   logic [1:0]       w_ex_ctr;
   logic [1:0]       w_ex_ctr_next;
   logic             w_retire;
   logic             w_wrong;

   // ID lookup reads the table array directly, so a same-cycle EX update
   // to the same entry is seen only on the following cycle.
   assign w_id_idx        = ID_PC_i[IDX_W+1:2];
   assign ID_PredTaken_o  = ID_Branch_i & r_bht[w_id_idx][1];
   assign ID_PredTarget_o = ID_Target_i;

   assign w_wrong           = r_ex_valid & (r_ex_pred ^ EX_Taken_i);
   assign EX_WrongPredict_o = w_wrong;
   assign EX_RecoverPC_o    = EX_Taken_i ? r_ex_target : r_ex_pcplus4;

   // A branch trains and counts only on the edge it leaves EX.
   assign w_retire = r_ex_valid & WriteMEM_i;
   assign w_ex_ctr = r_bht[r_ex_idx];

   always_comb begin
      w_ex_ctr_next = w_ex_ctr;
      if (EX_Taken_i) begin
         if (w_ex_ctr != 2'b11) w_ex_ctr_next = w_ex_ctr + 2'b01;
      end else begin
         if (w_ex_ctr != 2'b00) w_ex_ctr_next = w_ex_ctr - 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_bht[i] <= 2'b01;
      end else if (w_retire) begin
         r_bht[r_ex_idx] <= w_ex_ctr_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_valid   <= 1'b0;
         r_ex_pred    <= 1'b0;
         r_ex_idx     <= '0;
         r_ex_pcplus4 <= '0;
         r_ex_target  <= '0;
      end else if (FlushEX_i) begin
         r_ex_valid <= 1'b0;
      end else if (WriteEX_i) begin
         r_ex_valid   <= ID_Branch_i;
         r_ex_pred    <= ID_PredTaken_o;
         r_ex_idx     <= w_id_idx;
         r_ex_pcplus4 <= ID_PC_i + XLEN'(4);
         r_ex_target  <= ID_Target_i;
      end
   end

   // Performance counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_br_cnt   <= '0;
         r_miss_cnt <= '0;
      end else if (w_retire) begin
         if (r_br_cnt != 32'hFFFF_FFFF) r_br_cnt <= r_br_cnt + 32'd1;
         if (w_wrong && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign BrCnt_o   = r_br_cnt;
   assign MissCnt_o = r_miss_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: training, saturation,
// stall hold, flush, aliasing, read-before-write and mid-run reset.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic        ID_Branch_i;
   logic [31:0] ID_PC_i;
   logic [31:0] ID_Target_i;
   logic        ID_PredTaken_o;
   logic [31:0] ID_PredTarget_o;
   logic        WriteEX_i;
   logic        FlushEX_i;
   logic        WriteMEM_i;
   logic        EX_Taken_i;
   logic        EX_WrongPredict_o;
   logic [31:0] EX_RecoverPC_o;
   logic [31:0] BrCnt_o;
   logic [31:0] MissCnt_o;

   int checks   = 0;
   int failures = 0;

   branch_predictor #(.IDX_W(4), .XLEN(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .ID_Branch_i       (ID_Branch_i),
      .ID_PC_i           (ID_PC_i),
      .ID_Target_i       (ID_Target_i),
      .ID_PredTaken_o    (ID_PredTaken_o),
      .ID_PredTarget_o   (ID_PredTarget_o),
      .WriteEX_i         (WriteEX_i),
      .FlushEX_i         (FlushEX_i),
      .WriteMEM_i        (WriteMEM_i),
      .EX_Taken_i        (EX_Taken_i),
      .EX_WrongPredict_o (EX_WrongPredict_o),
      .EX_RecoverPC_o    (EX_RecoverPC_o),
      .BrCnt_o           (BrCnt_o),
      .MissCnt_o         (MissCnt_o)
   );

   always #5 clk = ~clk;

   // Advance one edge, then let inputs/outputs settle away from it.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic br, input logic [31:0] pc, input logic [31:0] tgt);
      ID_Branch_i = br;
      ID_PC_i     = pc;
      ID_Target_i = tgt;
      #1;
   endtask

   initial begin
      rst = 1'b1; WriteEX_i = 1'b1; FlushEX_i = 1'b0; WriteMEM_i = 1'b1; EX_Taken_i = 1'b0;
      set_id(1'b0, 32'h0, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_wrong",   {31'b0, EX_WrongPredict_o}, 32'd0);
      check("rst_recover", EX_RecoverPC_o, 32'h0);
      check("rst_brcnt",   BrCnt_o, 32'd0);
      check("rst_misscnt", MissCnt_o, 32'd0);
      set_id(1'b1, 32'h40, 32'h100);
      check("rst_pred_0x40", {31'b0, ID_PredTaken_o}, 32'd0);
      check("pred_target",   ID_PredTarget_o, 32'h100);

      // Three back-to-back taken passes of the branch at 0x40.
      EX_Taken_i = 1'b1;
      tick();                                       // pass1 -> EX, pass2 in ID
      check("p1_wrong",   {31'b0, EX_WrongPredict_o}, 32'd1);
      check("p1_recover", EX_RecoverPC_o, 32'h100);
      check("p2_pred_rbw", {31'b0, ID_PredTaken_o}, 32'd0);
      tick();                                       // bht[0]=10, pass2 -> EX
      check("p2_wrong",   {31'b0, EX_WrongPredict_o}, 32'd1);
      check("p3_pred",    {31'b0, ID_PredTaken_o}, 32'd1);
      check("p2_brcnt",   BrCnt_o, 32'd1);
      check("p2_misscnt", MissCnt_o, 32'd1);
      tick();                                       // bht[0]=11, pass3 -> EX
      set_id(1'b0, 32'h0, 32'h0);
      check("p3_wrong",   {31'b0, EX_WrongPredict_o}, 32'd0);
      tick();                                       // bht[0] stays 11
      check("p3_brcnt",   BrCnt_o, 32'd3);
      check("p3_misscnt", MissCnt_o, 32'd2);
      check("bubble_wrong", {31'b0, EX_WrongPredict_o}, 32'd0);

      // Aliased PC 0x80 shares idx 0 and now predicts taken.
      set_id(1'b1, 32'h80, 32'h200);
      check("alias_pred_0x80", {31'b0, ID_PredTaken_o}, 32'd1);
      set_id(1'b0, 32'h40, 32'h100);
      check("nobranch_pred", {31'b0, ID_PredTaken_o}, 32'd0);

      // Strong-T entry resolves not-taken, held under a 5-cycle memory stall.
      set_id(1'b1, 32'h40, 32'h100);
      check("st_pred", {31'b0, ID_PredTaken_o}, 32'd1);
      EX_Taken_i = 1'b0;
      tick();
      set_id(1'b0, 32'h0, 32'h0);
      WriteMEM_i = 1'b0; WriteEX_i = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stall%0d_wrong", i),   {31'b0, EX_WrongPredict_o}, 32'd1);
         check($sformatf("stall%0d_recover", i), EX_RecoverPC_o, 32'h44);
         tick();
      end
      check("stall_brcnt",   BrCnt_o, 32'd3);
      check("stall_misscnt", MissCnt_o, 32'd2);
      WriteMEM_i = 1'b1; WriteEX_i = 1'b1;
      tick();                                       // single update: bht[0]=10
      check("rel_brcnt",   BrCnt_o, 32'd4);
      check("rel_misscnt", MissCnt_o, 32'd3);
      check("rel_wrong",   {31'b0, EX_WrongPredict_o}, 32'd0);
      tick();
      check("post_brcnt",   BrCnt_o, 32'd4);
      check("post_misscnt", MissCnt_o, 32'd3);
      set_id(1'b1, 32'h40, 32'h100);
      check("weakT_pred", {31'b0, ID_PredTaken_o}, 32'd1);

      // Flush beats write: the ID branch never becomes valid in EX.
      FlushEX_i = 1'b1;
      tick();
      FlushEX_i = 1'b0;
      set_id(1'b0, 32'h0, 32'h0);
      check("flush_wrong", {31'b0, EX_WrongPredict_o}, 32'd0);
      tick();
      check("flush_brcnt",   BrCnt_o, 32'd4);
      check("flush_misscnt", MissCnt_o, 32'd3);
      set_id(1'b1, 32'h40, 32'h100);
      check("flush_pred", {31'b0, ID_PredTaken_o}, 32'd1);

      // Reset with a mispredicting branch in EX discards it.
      tick();
      check("pre_rst_wrong", {31'b0, EX_WrongPredict_o}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_id(1'b0, 32'h0, 32'h0);
      check("rst2_wrong",   {31'b0, EX_WrongPredict_o}, 32'd0);
      check("rst2_recover", EX_RecoverPC_o, 32'h0);
      check("rst2_brcnt",   BrCnt_o, 32'd0);
      check("rst2_misscnt", MissCnt_o, 32'd0);
      set_id(1'b1, 32'h40, 32'h100);
      check("rst2_pred", {31'b0, ID_PredTaken_o}, 32'd0);
      tick();
      check("rst2_after_brcnt", BrCnt_o, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- 2-bit saturating-counter branch history table (BHT) for the 5-stage pipeline.
- ID stage: looks up conditional branches and supplies a taken/not-taken prediction plus the redirect target to the fetch mux.
- EX stage: compares the carried prediction against the resolved outcome and produces EX_WrongPredict_o and the recovery PC. EX_WrongPredict_o feeds the stall controller's EX_WrongPredict_i.
- Also keeps branch and mispredict performance counters.

Parameters:
- IDX_W, 4: BHT index width; table depth = 2**IDX_W entries.
- XLEN, 32: PC/address width.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  reset, synchronous, active-high
- ID_Branch_i  input  1  ID holds a valid conditional branch (0 for bubbles and flushed slots)
- ID_PC_i  input  XLEN  PC of the ID instruction
- ID_Target_i  input  XLEN  branch target computed in ID
- ID_PredTaken_o  output  1  prediction for the ID branch; 0 when ID_Branch_i=0
- ID_PredTarget_o  output  XLEN  equals ID_Target_i (fetch-mux redirect when ID_PredTaken_o=1)
- WriteEX_i  input  1  stall-controller enable for the ID/EX register
- FlushEX_i  input  1  stall-controller bubble insert into EX
- WriteMEM_i  input  1  stall-controller enable for EX/MEM; EX instruction advances this cycle
- EX_Taken_i  input  1  resolved branch outcome from the EX comparator
- EX_WrongPredict_o  output  1  EX branch mispredicted
- EX_RecoverPC_o  output  XLEN  correct next PC on mispredict
- BrCnt_o  output  32  resolved-branch count
- MissCnt_o  output  32  mispredict count

Behaviour:
- Index function: idx = PC[IDX_W+1:2].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken = counter[1].
- Reset (rst=1 at a clk edge):
  - every BHT entry is set to 01;
  - ex_valid is cleared;
  - BrCnt_o and MissCnt_o are cleared;
  - EX_WrongPredict_o=0 and EX_RecoverPC_o=0 from the next cycle onward.
  - Reset mid-operation discards any in-flight EX branch; no update is performed.
- ID lookup is combinational: ID_PredTaken_o = ID_Branch_i & bht[idx(ID_PC_i)][1].
- EX register (ex_valid, ex_pred, ex_idx, ex_pcplus4, ex_target), updated each clk edge:
  - FlushEX_i=1: ex_valid <= 0. Flush has priority over WriteEX_i.
  - else WriteEX_i=1: ex_valid <= ID_Branch_i, ex_pred <= ID_PredTaken_o, ex_idx <= idx(ID_PC_i), ex_pcplus4 <= ID_PC_i+4 (mod 2**XLEN), ex_target <= ID_Target_i.
  - else: hold all fields.
- Resolution is combinational on the EX register:
  - EX_WrongPredict_o = ex_valid & (ex_pred ^ EX_Taken_i).
  - EX_RecoverPC_o = EX_Taken_i ? ex_target : ex_pcplus4. It is also driven when not mispredicting; consumers qualify it with EX_WrongPredict_o.
  - Under a memory stall (WriteMEM_i=0) the mispredict stays asserted and stable until the stage advances.
- Training and counting happen only on the edge where ex_valid=1 and WriteMEM_i=1:
  - Exactly one update per branch, regardless of stall length.
  - bht[ex_idx]: taken increments, not-taken decrements, saturating at 11 and 00.
  - BrCnt_o += 1; MissCnt_o += 1 if mispredicted. Both saturate at 32'hFFFF_FFFF and never wrap.
- Same-cycle ID lookup and EX update to the same index: the lookup returns the pre-update value (read-before-write, no bypass).
- Aliasing: distinct PCs with equal idx share an entry. This is intended; there are no tags.

Test Plan:
- Reset → BHT all 01. Branch at PC 0x40 in ID → ID_PredTaken_o=0. BrCnt_o=MissCnt_o=0, EX_WrongPredict_o=0.
- Branch PC 0x40, target 0x100, resolved taken 3 times → mispredicts on passes 1–2, correct on pass 3. MissCnt_o=2, BrCnt_o=3, bht[0]=11 saturated. On the first pass EX_RecoverPC_o=0x100.
- Strong-T entry, branch resolves not-taken → EX_WrongPredict_o=1, EX_RecoverPC_o=PC+4=0x44, entry becomes 10. Prediction stays taken next time.
- Mispredicting branch in EX with WriteMEM_i=0 for 5 cycles → EX_WrongPredict_o held 1 for all 5 cycles. Counter moves one step only; MissCnt_o increments by exactly 1 on release.
- FlushEX_i=1 with WriteEX_i=1 while ID_Branch_i=1 → ex_valid=0: no mispredict, no BHT or counter change.
- PCs 0x40 and 0x80 (IDX_W=4, same idx 0) → training 0x40 taken changes the prediction for 0x80. Same-cycle EX update and ID lookup of idx 0 returns the old value.
